mem_stage_lsu: RTL and testbench
================================

// Module: mem_stage_lsu
// PURPOSE
//  MEM-stage load/store unit between the EX/MEM pipeline register and the word-wide data RAM.
//  - Loads: drives a word read, then extracts and sign/zero-extends the addressed byte, half or word.
//  - Stores: SW writes directly. SB/SH use a 2-cycle read-modify-write, because the RAM has no byte enables.
//  - Registers the MEM/WB result and raises alignment, range and encoding errors.
// PARAMETERS
//  XLEN       32    data/address width; only 32 is supported
//  MEM_DEPTH  1024  RAM depth in words; byte addresses >= MEM_DEPTH*4 are access faults
// PORTS
//  clk_100MHz   in   1     single clock; all state updates on posedge
//  arst_n       in   1     asynchronous, active-low reset
//  mem_req_i    in   1     EX/MEM slot holds a load/store
//  mem_we_i     in   1     1=store, 0=load (valid only with mem_req_i)
//  mem_funct3_i in   3     RV32I funct3: LB000 LH001 LW010 LBU100 LHU101 / SB000 SH001 SW010
//  mem_addr_i   in   32    effective byte address
//  mem_wdata_i  in   32    store data (rs2)
//  ex_result_i  in   32    ALU result forwarded when mem_req_i=0
//  rd_addr_i    in   5     destination register
//  rd_we_i      in   1     destination write enable
//  stall_o      out  1     combinational; holds IF..EX/MEM during the RMW read cycle
//  r_ena_o      out  1     RAM read enable
//  r_addr_o     out  32    RAM read byte address, [1:0]=0
//  r_data_i     in   32    RAM read word (combinational, same cycle)
//  w_ena_o      out  1     RAM write enable
//  w_addr_o     out  32    RAM write byte address, [1:0]=0
//  w_data_o     out  32    RAM write word
//  wb_data_o    out  32    registered MEM/WB data
//  wb_rd_addr_o out  5     registered MEM/WB destination
//  wb_rd_we_o   out  1     registered MEM/WB write enable
//  err_o        out  1     registered 1-cycle error pulse
//  err_cause_o  out  2     00 access fault, 01 misaligned load, 10 misaligned store, 11 illegal funct3
// BEHAVIOUR
//  Reset (async, arst_n=0): state=IDLE, merge_q=0.
//   All registered outputs go to 0: wb_*, err_*, w_addr_o, w_data_o.
//   A reset during RMW_WRITE discards the merge and performs no write.
//  Write-port hold: when w_ena_o=0, w_addr_o and w_data_o keep the last committed write.
//   A re-write of that value is idempotent.
//   A same-address bypass read returns the true memory contents.
//  Checks (IDLE, mem_req_i=1), in priority order:
//   1. Illegal funct3: loads 011/110/111, stores 1xx -> cause 11.
//   2. Misaligned: half with addr[0]!=0, or word with addr[1:0]!=0 -> cause 01 (load) / 10 (store).
//   3. Access fault: addr >= MEM_DEPTH*4 -> cause 00.
//   On any error: no RAM access, no stall, wb_rd_we_o<=0, err_o<=1 for one cycle.
//  FSM states IDLE and RMW_WRITE:
//   IDLE, load: r_ena_o=1, r_addr_o={addr[31:2],2'b00}.
//    Lane = addr[1:0] (byte) or addr[1] (half); extend per funct3.
//    Next edge: wb_data_o=result, wb_rd_we_o=rd_we_i. Latency 1 cycle, stall_o=0.
//   IDLE, SW: w_ena_o=1 with word address and mem_wdata_i; no stall; wb_rd_we_o<=0.
//   IDLE, SB/SH: r_ena_o=1, stall_o=1.
//    merge_q <= r_data_i with the addressed lane replaced by wdata[7:0] or [15:0].
//    Go to RMW_WRITE. wb_rd_we_o<=0 (bubble).
//   RMW_WRITE: w_ena_o=1, w_data_o=merge_q, w_addr_o=latched word address, stall_o=0.
//    Inputs (the same held store) are consumed. Go to IDLE; wb_rd_we_o<=0.
//   IDLE, mem_req_i=0: wb_data_o<=ex_result_i, wb_rd_we_o<=rd_we_i.
//    r_ena_o=0, w_ena_o=0.
//  Load directly after a store to the same word: the write commits at the store's final edge.
//   The load reads updated RAM next cycle; no extra hazard logic.
//  wb_rd_addr_o<=rd_addr_i whenever wb updates.
// STRUCTURE
//  define.v: funct3 codes, error-cause codes, LSU state encodings, XLEN.
//  Sub-module lsu_align (combinational):
//   load lane select + sign/zero extend;
//   store lane merge (word, byte offset, wdata, size) -> merged word.
//  Top: FSM, merge/address latch, checks, MEM/WB registers.
// TESTING
//  1. Reset 0x0000_0000 + arst_n low mid-SB RMW -> no write, all outputs 0, state IDLE.
//  2. SW 0x8000_00FF @0x10; LB @0x10 -> 0xFFFF_FFFF; LBU @0x13 -> 0x0000_0080; LH @0x12 -> 0xFFFF_8000.
//  3. Word 0x1122_3344 @0x20; SB 0xAA @0x21:
//     stall_o=1 for 1 cycle, then write 0x1122_AA44; LW @0x20 -> 0x1122_AA44.
//  4. SH 0xBEEF @0x22 over 0x1122_AA44 -> 0xBEEF_AA44; back-to-back SB, SB -> 2 stalls, both merges kept.
//  5. LW @0x6 -> err_o=1, cause 01, no r_ena_o; SH @0x3 -> cause 10;
//     funct3 011 load -> cause 11; LW @0x1000 (depth 1024) -> cause 00.
//  6. Non-memory op, ex_result 0x1234, rd=5 -> wb_data_o=0x1234, wb_rd_we_o=1 next cycle; no RAM enables.

Source files
------------

// File: rtl/mem_stage_lsu_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_lsu_pkg
// Shared constants for the MEM-stage load/store unit: data width, RV32I
// load/store funct3 codes, error-cause codes, FSM state encodings, and the
// access-size type with its decode helper.
// -----------------------------------------------------------------------------
package mem_stage_lsu_pkg;

  localparam int LSU_XLEN = 32;

  // RV32I load/store funct3 (stores share the low codes with loads)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // err_cause_o encodings
  localparam logic [1:0] CAUSE_ACCESS_FAULT = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN_LD  = 2'b01;
  localparam logic [1:0] CAUSE_MISALIGN_ST  = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL_F3   = 2'b11;

  // FSM state encodings
  localparam logic [0:0] ST_IDLE      = 1'b0;
  localparam logic [0:0] ST_RMW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } lsu_size_e;

  // Access size from funct3[1:0]; the unsigned bit (funct3[2]) is handled separately.
  function automatic lsu_size_e size_of(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return SIZE_BYTE;
      2'b01:   return SIZE_HALF;
      default: return SIZE_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// -----------------------------------------------------------------------------
// mem_stage_lsu_align
// Purely combinational lane logic shared by loads and sub-word stores.
//   word_i       : word read from RAM
//   offset_i     : byte offset inside the word (addr[1:0])
//   size_i       : access size (lsu_size_e encoding)
//   unsigned_i   : 1 = zero-extend load, 0 = sign-extend
//   wdata_i      : store data; low byte/half is merged for SB/SH
//   load_data_o  : selected lane, extended to 32 bits
//   merge_data_o : word_i with the addressed lane replaced by store data
// -----------------------------------------------------------------------------
module mem_stage_lsu_align
  import mem_stage_lsu_pkg::*;
(
  input  logic [LSU_XLEN-1:0] word_i,
  input  logic [1:0]          offset_i,
  input  logic [1:0]          size_i,
  input  logic                unsigned_i,
  input  logic [LSU_XLEN-1:0] wdata_i,
  output logic [LSU_XLEN-1:0] load_data_o,
  output logic [LSU_XLEN-1:0] merge_data_o
);

  lsu_size_e   size;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // NOTE: every variable assigned in an always_comb gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    size      = lsu_size_e'(size_i);
    byte_lane = word_i[{offset_i, 3'b000} +: 8];
    // Halves are selected by addr[1] only; addr[0] is guaranteed 0 by the alignment check.
    half_lane = word_i[{offset_i[1], 4'b0000} +: 16];

    case (size)
      SIZE_BYTE: load_data_o = unsigned_i ? {24'h0, byte_lane}
                                          : {{24{byte_lane[7]}}, byte_lane};
      SIZE_HALF: load_data_o = unsigned_i ? {16'h0, half_lane}
                                          : {{16{half_lane[15]}}, half_lane};
      default:   load_data_o = word_i;
    endcase

    merge_data_o = word_i;
    case (size)
      SIZE_BYTE: merge_data_o[{offset_i, 3'b000} +: 8]      = wdata_i[7:0];
      SIZE_HALF: merge_data_o[{offset_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default:   merge_data_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// mem_stage_lsu
// MEM-stage load/store unit between the EX/MEM register and a word-wide RAM
// without byte enables. Loads read and extend in one cycle; SW writes
// directly; SB/SH take a read cycle (stalling the front end) followed by a
// write of the merged word. Produces the registered MEM/WB result and a
// one-cycle error pulse for illegal funct3, misalignment and range faults.
//
// Ports
//   clk_100MHz, arst_n          : clock, async active-low reset
//   mem_req_i/we_i/funct3_i     : memory op present / store / RV32I funct3
//   mem_addr_i, mem_wdata_i     : effective byte address, store data
//   ex_result_i, rd_addr_i/we_i : ALU result and destination from EX/MEM
//   stall_o                     : holds IF..EX/MEM during the RMW read cycle
//   r_ena_o/r_addr_o/r_data_i   : RAM read port (combinational data)
//   w_ena_o/w_addr_o/w_data_o   : RAM write port (addr/data hold last write)
//   wb_data_o/rd_addr_o/rd_we_o : MEM/WB register
//   err_o, err_cause_o          : registered error pulse and cause
// -----------------------------------------------------------------------------
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int MEM_DEPTH = 1024
) (
  input  logic            clk_100MHz,
  input  logic            arst_n,
  input  logic            mem_req_i,
  input  logic            mem_we_i,
  input  logic [2:0]      mem_funct3_i,
  input  logic [XLEN-1:0] mem_addr_i,
  input  logic [XLEN-1:0] mem_wdata_i,
  input  logic [XLEN-1:0] ex_result_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            rd_we_i,
  output logic            stall_o,
  output logic            r_ena_o,
  output logic [XLEN-1:0] r_addr_o,
  input  logic [XLEN-1:0] r_data_i,
  output logic            w_ena_o,
  output logic [XLEN-1:0] w_addr_o,
  output logic [XLEN-1:0] w_data_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic [4:0]      wb_rd_addr_o,
  output logic            wb_rd_we_o,
  output logic            err_o,
  output logic [1:0]      err_cause_o
);

  localparam logic [XLEN-1:0] ADDR_LIMIT = XLEN'(MEM_DEPTH * 4);

  logic [0:0]      state_q, state_d;
  logic [XLEN-1:0] merge_q, merge_d;
  logic [XLEN-1:0] rmw_addr_q, rmw_addr_d;
  logic [XLEN-1:0] w_addr_q, w_data_q;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic [4:0]      wb_rd_addr_q, wb_rd_addr_d;
  logic            wb_rd_we_q, wb_rd_we_d;
  logic            err_q, err_d;
  logic [1:0]      err_cause_q, err_cause_d;

  lsu_size_e       size;
  logic            in_rmw_write, req_idle;
  logic            illegal, misaligned, out_of_range, err_any;
  logic [1:0]      cause;
  logic            do_load, do_sw, do_rmw;
  logic [XLEN-1:0] word_addr, load_data, merge_data;

  // ---------------------------------------------------------------------------
  // Decode and checks (only meaningful for a request seen in IDLE)
  // ---------------------------------------------------------------------------
  always_comb begin
    size         = size_of(mem_funct3_i);
    in_rmw_write = (state_q == ST_RMW_WRITE);
    req_idle     = mem_req_i && !in_rmw_write;
    word_addr    = {mem_addr_i[XLEN-1:2], 2'b00};

    // funct3 011 is not an RV32I store either (it would be SD), so it joins 1xx.
    if (mem_we_i) illegal = mem_funct3_i[2] || (mem_funct3_i[1:0] == 2'b11);
    else          illegal = (mem_funct3_i == 3'b011) || (mem_funct3_i[2:1] == 2'b11);

    misaligned   = ((size == SIZE_HALF) && mem_addr_i[0]) ||
                   ((size == SIZE_WORD) && (mem_addr_i[1:0] != 2'b00));
    out_of_range = (mem_addr_i >= ADDR_LIMIT);

    if (illegal)         cause = CAUSE_ILLEGAL_F3;
    else if (misaligned) cause = mem_we_i ? CAUSE_MISALIGN_ST : CAUSE_MISALIGN_LD;
    else                 cause = CAUSE_ACCESS_FAULT;

    err_any = req_idle && (illegal || misaligned || out_of_range);
    do_load = req_idle && !err_any && !mem_we_i;
    do_sw   = req_idle && !err_any && mem_we_i && (size == SIZE_WORD);
    do_rmw  = req_idle && !err_any && mem_we_i && (size != SIZE_WORD);
  end

  mem_stage_lsu_align u_align (
    .word_i       (r_data_i),
    .offset_i     (mem_addr_i[1:0]),
    .size_i       (size),
    .unsigned_i   (mem_funct3_i[2]),
    .wdata_i      (mem_wdata_i),
    .load_data_o  (load_data),
    .merge_data_o (merge_data)
  );

  // ---------------------------------------------------------------------------
  // RAM ports. When idle, the write port shows the last committed write so a
  // spurious sample of it is a harmless re-write of the same value.
  // ---------------------------------------------------------------------------
  always_comb begin
    r_ena_o  = do_load || do_rmw;
    r_addr_o = word_addr;
    stall_o  = do_rmw;
    w_ena_o  = do_sw || in_rmw_write;
    if (in_rmw_write) begin
      w_addr_o = rmw_addr_q;
      w_data_o = merge_q;
    end else if (do_sw) begin
      w_addr_o = word_addr;
      w_data_o = mem_wdata_i;
    end else begin
      w_addr_o = w_addr_q;
      w_data_o = w_data_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state: FSM, merge latch, MEM/WB register
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    merge_d      = merge_q;
    rmw_addr_d   = rmw_addr_q;
    wb_data_d    = wb_data_q;
    wb_rd_addr_d = wb_rd_addr_q;
    wb_rd_we_d   = wb_rd_we_q;
    err_d        = 1'b0;
    err_cause_d  = err_cause_q;

    if (in_rmw_write) begin
      // The held store is consumed here; the write itself happens on this edge.
      state_d    = ST_IDLE;
      wb_rd_we_d = 1'b0;
    end else if (!mem_req_i) begin
      wb_data_d    = ex_result_i;
      wb_rd_addr_d = rd_addr_i;
      wb_rd_we_d   = rd_we_i;
    end else if (err_any) begin
      wb_rd_we_d  = 1'b0;
      err_d       = 1'b1;
      err_cause_d = cause;
    end else if (do_load) begin
      wb_data_d    = load_data;
      wb_rd_addr_d = rd_addr_i;
      wb_rd_we_d   = rd_we_i;
    end else begin
      // Stores write no register; SB/SH also inject a bubble while merging.
      wb_rd_we_d = 1'b0;
      if (do_rmw) begin
        state_d    = ST_RMW_WRITE;
        merge_d    = merge_data;
        rmw_addr_d = word_addr;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_100MHz or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= ST_IDLE;
      merge_q      <= '0;
      rmw_addr_q   <= '0;
      w_addr_q     <= '0;
      w_data_q     <= '0;
      wb_data_q    <= '0;
      wb_rd_addr_q <= '0;
      wb_rd_we_q   <= 1'b0;
      err_q        <= 1'b0;
      err_cause_q  <= '0;
    end else begin
      state_q      <= state_d;
      merge_q      <= merge_d;
      rmw_addr_q   <= rmw_addr_d;
      wb_data_q    <= wb_data_d;
      wb_rd_addr_q <= wb_rd_addr_d;
      wb_rd_we_q   <= wb_rd_we_d;
      err_q        <= err_d;
      err_cause_q  <= err_cause_d;
      if (w_ena_o) begin
        w_addr_q <= w_addr_o;
        w_data_q <= w_data_o;
      end
    end
  end

  assign wb_data_o    = wb_data_q;
  assign wb_rd_addr_o = wb_rd_addr_q;
  assign wb_rd_we_o   = wb_rd_we_q;
  assign err_o        = err_q;
  assign err_cause_o  = err_cause_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_lsu
// Directed bench for mem_stage_lsu with a 1024-word RAM model: reset and
// reset during RMW, load extension, SB/SH read-modify-write, error checks
// and ALU pass-through. Inputs change 1 ns after posedge; combinational
// outputs are checked at negedge, registered outputs 1 ns after posedge.
// -----------------------------------------------------------------------------
module tb_mem_stage_lsu;

  logic        clk_100MHz = 1'b0;
  logic        arst_n;
  logic        mem_req_i, mem_we_i, rd_we_i;
  logic [2:0]  mem_funct3_i;
  logic [31:0] mem_addr_i, mem_wdata_i, ex_result_i;
  logic [4:0]  rd_addr_i;
  logic        stall_o, r_ena_o, w_ena_o, wb_rd_we_o, err_o;
  logic [31:0] r_addr_o, r_data_i, w_addr_o, w_data_o, wb_data_o;
  logic [4:0]  wb_rd_addr_o;
  logic [1:0]  err_cause_o;

  int tests_run   = 0;
  int tests_failed = 0;
  int writes      = 0;
  int stall_count = 0;

  logic [31:0] ram [0:1023];

  always #5 clk_100MHz = ~clk_100MHz;

  mem_stage_lsu #(.XLEN(32), .MEM_DEPTH(1024)) dut (
    .clk_100MHz   (clk_100MHz),
    .arst_n       (arst_n),
    .mem_req_i    (mem_req_i),
    .mem_we_i     (mem_we_i),
    .mem_funct3_i (mem_funct3_i),
    .mem_addr_i   (mem_addr_i),
    .mem_wdata_i  (mem_wdata_i),
    .ex_result_i  (ex_result_i),
    .rd_addr_i    (rd_addr_i),
    .rd_we_i      (rd_we_i),
    .stall_o      (stall_o),
    .r_ena_o      (r_ena_o),
    .r_addr_o     (r_addr_o),
    .r_data_i     (r_data_i),
    .w_ena_o      (w_ena_o),
    .w_addr_o     (w_addr_o),
    .w_data_o     (w_data_o),
    .wb_data_o    (wb_data_o),
    .wb_rd_addr_o (wb_rd_addr_o),
    .wb_rd_we_o   (wb_rd_we_o),
    .err_o        (err_o),
    .err_cause_o  (err_cause_o)
  );

  // RAM model: combinational read, write on posedge
  assign r_data_i = ram[r_addr_o[11:2]];

  always @(posedge clk_100MHz) begin
    if (w_ena_o) begin
      ram[w_addr_o[11:2]] <= w_data_o;
      writes <= writes + 1;
    end
  end

  always @(negedge clk_100MHz) begin
    if (stall_o) stall_count <= stall_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic set_op(input logic req, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exr, input logic [4:0] rd, input logic rdwe);
    mem_req_i    = req;
    mem_we_i     = we;
    mem_funct3_i = f3;
    mem_addr_i   = addr;
    mem_wdata_i  = wd;
    ex_result_i  = exr;
    rd_addr_i    = rd;
    rd_we_i      = rdwe;
  endtask

  task automatic idle();
    set_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
  endtask

  task automatic do_sw(input string tag, input logic [31:0] addr, input logic [31:0] wd);
    set_op(1'b1, 1'b1, 3'b010, addr, wd, 32'h0, 5'd7, 1'b1);
    @(negedge clk_100MHz);
    check({tag, " w_ena"}, {31'h0, w_ena_o}, 32'h1);
    check({tag, " w_addr"}, w_addr_o, addr);
    check({tag, " w_data"}, w_data_o, wd);
    check({tag, " stall"}, {31'h0, stall_o}, 32'h0);
    tick();
    check({tag, " wb_we"}, {31'h0, wb_rd_we_o}, 32'h0);
    idle();
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [4:0] rd, input logic [31:0] exp);
    logic [31:0] waddr;
    waddr = {addr[31:2], 2'b00};
    set_op(1'b1, 1'b0, f3, addr, 32'h0, 32'h0, rd, 1'b1);
    @(negedge clk_100MHz);
    check({tag, " r_ena"}, {31'h0, r_ena_o}, 32'h1);
    check({tag, " r_addr"}, r_addr_o, waddr);
    check({tag, " stall"}, {31'h0, stall_o}, 32'h0);
    tick();
    check({tag, " wb_data"}, wb_data_o, exp);
    check({tag, " wb_we"}, {31'h0, wb_rd_we_o}, 32'h1);
    check({tag, " wb_rd"}, {27'h0, wb_rd_addr_o}, {27'h0, rd});
    idle();
  endtask

  task automatic do_rmw(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_word);
    logic [31:0] waddr;
    waddr = {addr[31:2], 2'b00};
    set_op(1'b1, 1'b1, f3, addr, wd, 32'h0, 5'd9, 1'b1);
    @(negedge clk_100MHz);
    check({tag, " rd stall"}, {31'h0, stall_o}, 32'h1);
    check({tag, " rd r_ena"}, {31'h0, r_ena_o}, 32'h1);
    check({tag, " rd w_ena"}, {31'h0, w_ena_o}, 32'h0);
    tick();
    check({tag, " bubble wb_we"}, {31'h0, wb_rd_we_o}, 32'h0);
    @(negedge clk_100MHz);
    check({tag, " wr stall"}, {31'h0, stall_o}, 32'h0);
    check({tag, " wr w_ena"}, {31'h0, w_ena_o}, 32'h1);
    check({tag, " wr w_addr"}, w_addr_o, waddr);
    check({tag, " wr w_data"}, w_data_o, exp_word);
    tick();
    check({tag, " done wb_we"}, {31'h0, wb_rd_we_o}, 32'h0);
    idle();
  endtask

  task automatic do_err(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [1:0] exp_cause);
    set_op(1'b1, we, f3, addr, 32'hDEAD_BEEF, 32'h0, 5'd3, 1'b1);
    @(negedge clk_100MHz);
    check({tag, " r_ena"}, {31'h0, r_ena_o}, 32'h0);
    check({tag, " w_ena"}, {31'h0, w_ena_o}, 32'h0);
    check({tag, " stall"}, {31'h0, stall_o}, 32'h0);
    tick();
    check({tag, " err"}, {31'h0, err_o}, 32'h1);
    check({tag, " cause"}, {30'h0, err_cause_o}, {30'h0, exp_cause});
    check({tag, " wb_we"}, {31'h0, wb_rd_we_o}, 32'h0);
    idle();
    tick();
    check({tag, " err pulse"}, {31'h0, err_o}, 32'h0);
  endtask

  int stalls_before;

  initial begin
    // ---- 1. Reset, then reset in the middle of an SB read-modify-write ----
    arst_n = 1'b0;
    idle();
    #12;
    check("rst wb_data", wb_data_o, 32'h0);
    check("rst wb_rd", {27'h0, wb_rd_addr_o}, 32'h0);
    check("rst wb_we", {31'h0, wb_rd_we_o}, 32'h0);
    check("rst err", {31'h0, err_o}, 32'h0);
    check("rst cause", {30'h0, err_cause_o}, 32'h0);
    check("rst w_addr", w_addr_o, 32'h0);
    check("rst w_data", w_data_o, 32'h0);
    check("rst w_ena", {31'h0, w_ena_o}, 32'h0);
    @(negedge clk_100MHz);
    arst_n = 1'b1;
    tick();

    do_sw("sw40", 32'h40, 32'h5566_7788);
    set_op(1'b1, 1'b1, 3'b000, 32'h41, 32'h0000_00AA, 32'h0, 5'd9, 1'b1);
    tick();
    check("mid-rmw w_ena", {31'h0, w_ena_o}, 32'h1);
    #1;
    arst_n = 1'b0;
    idle();
    #1;
    check("rmw-rst w_ena", {31'h0, w_ena_o}, 32'h0);
    check("rmw-rst w_addr", w_addr_o, 32'h0);
    check("rmw-rst w_data", w_data_o, 32'h0);
    check("rmw-rst stall", {31'h0, stall_o}, 32'h0);
    check("rmw-rst wb_data", wb_data_o, 32'h0);
    tick();
    tick();
    check("rmw-rst writes", writes, 32'd1);
    check("rmw-rst ram", ram[32'h40 >> 2], 32'h5566_7788);
    @(negedge clk_100MHz);
    arst_n = 1'b1;
    tick();
    do_load("lw40", 3'b010, 32'h40, 5'd1, 32'h5566_7788);

    // ---- 2. Load extension ----
    do_sw("sw10", 32'h10, 32'h8000_00FF);
    do_load("lb10", 3'b000, 32'h10, 5'd2, 32'hFFFF_FFFF);
    check("hold w_addr", w_addr_o, 32'h10);
    check("hold w_data", w_data_o, 32'h8000_00FF);
    do_load("lbu13", 3'b100, 32'h13, 5'd3, 32'h0000_0080);
    do_load("lh12", 3'b001, 32'h12, 5'd4, 32'hFFFF_8000);
    do_load("lhu12", 3'b101, 32'h12, 5'd4, 32'h0000_8000);

    // ---- 3. SB read-modify-write ----
    do_sw("sw20", 32'h20, 32'h1122_3344);
    do_rmw("sb21", 3'b000, 32'h21, 32'h0000_00AA, 32'h1122_AA44);
    do_load("lw20a", 3'b010, 32'h20, 5'd6, 32'h1122_AA44);

    // ---- 4. SH, then back-to-back SB, SB ----
    do_rmw("sh22", 3'b001, 32'h22, 32'h0000_BEEF, 32'hBEEF_AA44);
    stalls_before = stall_count;
    do_rmw("sb20", 3'b000, 32'h20, 32'hFFFF_FF01, 32'hBEEF_AA01);
    do_rmw("sb23", 3'b000, 32'h23, 32'h0000_0002, 32'h02EF_AA01);
    check("b2b stalls", stall_count - stalls_before, 32'd2);
    do_load("lw20b", 3'b010, 32'h20, 5'd8, 32'h02EF_AA01);

    // ---- 5. Errors and range boundary ----
    do_err("lw6", 1'b0, 3'b010, 32'h6, 2'b01);
    do_err("sh3", 1'b1, 3'b001, 32'h3, 2'b10);
    do_err("ld011", 1'b0, 3'b011, 32'h0, 2'b11);
    do_err("lw1000", 1'b0, 3'b010, 32'h1000, 2'b00);
    do_err("lh1001", 1'b0, 3'b001, 32'h1001, 2'b01);
    do_err("sb100", 1'b1, 3'b100, 32'h1000, 2'b11);
    do_sw("swffc", 32'hFFC, 32'hCAFE_F00D);
    do_load("lwffc", 3'b010, 32'hFFC, 5'd10, 32'hCAFE_F00D);

    // ---- 6. Non-memory op passes the ALU result ----
    set_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0000_1234, 5'd5, 1'b1);
    @(negedge clk_100MHz);
    check("alu r_ena", {31'h0, r_ena_o}, 32'h0);
    check("alu w_ena", {31'h0, w_ena_o}, 32'h0);
    tick();
    check("alu wb_data", wb_data_o, 32'h0000_1234);
    check("alu wb_rd", {27'h0, wb_rd_addr_o}, 32'd5);
    check("alu wb_we", {31'h0, wb_rd_we_o}, 32'h1);
    idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
